// File: rtl/return_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : return_stack_ctrl
// Description : CALL/RET return-address stack with sticky overflow/underflow
//               fault state that freezes the stack until err_clr.
// Revision    : 1.0
// ============================================================================
module return_stack_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         stall,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            ret_addr,
    output logic [$clog2(DEPTH):0]       sp,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         fault
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_FAULT  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]      r_sp;
    logic [ADDR_W-1:0]     r_ret;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_do_push;
    logic                  w_do_pop;
    logic                  w_empty;
    logic                  w_full;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_top_idx;
    logic [IDX_W-1:0]      w_below_idx;

    assign w_empty     = (r_sp == '0);
    assign w_full      = (r_sp == PTR_W'(DEPTH));
    assign w_do_push   = push & ~stall & (r_state == S_NORMAL);
    assign w_do_pop    = pop  & ~stall & (r_state == S_NORMAL);
    // Low pointer bits wrap to the right slot even when sp==DEPTH.
    assign w_wr_idx    = r_sp[IDX_W-1:0];
    assign w_top_idx   = r_sp[IDX_W-1:0] - IDX_W'(1);
    assign w_below_idx = r_sp[IDX_W-1:0] - IDX_W'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_sp    <= '0;
            r_ret   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_state <= S_NORMAL;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    if (w_do_push && w_do_pop && !w_empty) begin
                        r_mem[w_top_idx] <= push_addr;
                        r_ret            <= push_addr;
                    end else if (w_do_push) begin
                        if (w_full) begin
                            r_ovf   <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_mem[w_wr_idx] <= push_addr;
                            r_sp            <= r_sp + PTR_W'(1);
                            r_ret           <= push_addr;
                        end
                    end else if (w_do_pop) begin
                        if (w_empty) begin
                            r_udf   <= 1'b1;
                            r_state <= S_FAULT;
                        end else if (r_sp == PTR_W'(1)) begin
                            r_sp  <= '0;
                            r_ret <= '0;
                        end else begin
                            r_sp  <= r_sp - PTR_W'(1);
                            r_ret <= r_mem[w_below_idx];
                        end
                    end
                end
                S_FAULT: begin
                    if (err_clr) begin
                        r_ovf   <= 1'b0;
                        r_udf   <= 1'b0;
                        r_state <= S_NORMAL;
                    end
                end
                default: r_state <= S_NORMAL;
            endcase
        end
    end

    assign ret_addr  = r_ret;
    assign sp        = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign fault     = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_return_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_stack_ctrl
// Description : Directed self-checking bench for return_stack_ctrl (DEPTH=4).
// Revision    : 1.0
// ============================================================================
module tb_return_stack_ctrl;

    localparam int ADDR_W = 19;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic              pop;
    logic              stall;
    logic [ADDR_W-1:0] push_addr;
    logic              err_clr;
    logic [ADDR_W-1:0] ret_addr;
    logic [PTR_W-1:0]  sp;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              fault;

    int errors = 0;
    int checks = 0;

    return_stack_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .stall     (stall),
        .push_addr (push_addr),
        .err_clr   (err_clr),
        .ret_addr  (ret_addr),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [ADDR_W-1:0] a);
        push = 1'b1; push_addr = a;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; push = 0; pop = 0; stall = 0; push_addr = '0; err_clr = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_sp", 32'(sp), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ret", 32'(ret_addr), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        chk("rst_fault", 32'(fault), 0);

        // Three pushes then three pops; ret_addr is checked in each pop cycle.
        do_push(19'h00010); do_push(19'h00020); do_push(19'h00030);
        chk("push3_sp", 32'(sp), 3);
        chk("push3_ret", 32'(ret_addr), 32'h30);
        pop = 1'b1;
        chk("pop1_ret", 32'(ret_addr), 32'h30); tick();
        chk("pop2_ret", 32'(ret_addr), 32'h20); tick();
        chk("pop3_ret", 32'(ret_addr), 32'h10); tick();
        pop = 1'b0;
        chk("drain_sp", 32'(sp), 0);
        chk("drain_ret", 32'(ret_addr), 0);
        chk("drain_empty", 32'(empty), 1);

        // Fill, then overflow.
        do_push(19'h00101); do_push(19'h00102); do_push(19'h00103); do_push(19'h00104);
        chk("fill_full", 32'(full), 1);
        chk("fill_sp", 32'(sp), 4);
        do_push(19'h7FFFF);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_fault", 32'(fault), 1);
        chk("ovf_sp", 32'(sp), 4);
        chk("ovf_ret", 32'(ret_addr), 32'h104);
        do_pop();
        chk("fault_pop_sp", 32'(sp), 4);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_udf", 32'(underflow), 0);
        chk("clr_fault", 32'(fault), 0);
        do_pop();
        chk("after_clr_sp", 32'(sp), 3);
        chk("after_clr_ret", 32'(ret_addr), 32'h103);

        // Drain and underflow.
        do_pop(); do_pop();
        chk("drain2_ret", 32'(ret_addr), 32'h101);
        do_pop();
        chk("drain3_sp", 32'(sp), 0);
        chk("drain3_ret", 32'(ret_addr), 0);
        do_pop();
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_fault", 32'(fault), 1);
        chk("udf_sp", 32'(sp), 0);
        chk("udf_ovf", 32'(overflow), 0);
        err_clr = 1'b1; push = 1'b1; push_addr = 19'h00005;
        tick();
        err_clr = 1'b0; push = 1'b0;
        chk("clrpush_sp", 32'(sp), 0);
        chk("clrpush_fault", 32'(fault), 0);
        chk("clrpush_udf", 32'(underflow), 0);
        chk("clrpush_ret", 32'(ret_addr), 0);

        // Replace-top with simultaneous push and pop.
        do_push(19'h00010); do_push(19'h00020);
        push = 1'b1; pop = 1'b1; push_addr = 19'h00099;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("repl_sp", 32'(sp), 2);
        chk("repl_ret", 32'(ret_addr), 32'h99);
        do_pop();
        chk("repl_pop_sp", 32'(sp), 1);
        chk("repl_pop_ret", 32'(ret_addr), 32'h10);

        // Held push under stall: only the unstalled cycle counts.
        push = 1'b1; push_addr = 19'h00055; stall = 1'b1;
        tick(); tick();
        chk("stall_sp", 32'(sp), 1);
        stall = 1'b0;
        tick();
        push = 1'b0;
        chk("unstall_sp", 32'(sp), 2);
        chk("unstall_ret", 32'(ret_addr), 32'h55);

        // Replace-top while full must not overflow.
        do_push(19'h00077); do_push(19'h00088);
        chk("full2", 32'(full), 1);
        push = 1'b1; pop = 1'b1; push_addr = 19'h0099A;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("fullrepl_sp", 32'(sp), 4);
        chk("fullrepl_ovf", 32'(overflow), 0);
        chk("fullrepl_fault", 32'(fault), 0);
        chk("fullrepl_ret", 32'(ret_addr), 32'h99A);
        do_pop();
        chk("fullrepl_pop_ret", 32'(ret_addr), 32'h77);
        chk("fullrepl_pop_sp", 32'(sp), 3);

        // Asynchronous reset between clock edges.
        push = 1'b1; push_addr = 19'h00066;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sp", 32'(sp), 0);
        chk("arst_ret", 32'(ret_addr), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_fault", 32'(fault), 0);
        push = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_arst_sp", 32'(sp), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/return_stack_ctrl.md
Name: return_stack_ctrl

Overview:
- Hardware call/return stack for the 19-bit CPU.
- Consumes the `push` (CALL) and `pop` (RET) strobes from the decode control unit.
- Stores return addresses (PC+1 of the CALL) and presents the current top-of-stack as the RET target.
- Tracks occupancy and detects overflow and underflow. A sticky fault state freezes the stack until software or a debug path clears it.

Parameters:
- ADDR_W, 19, width of a stored return address (instruction address width).
- DEPTH, 16, number of stack entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the occupancy counter (local, derived).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  CALL strobe from control; request to push push_addr.
- pop  input  1  RET strobe from control; request to pop the top entry.
- stall  input  1  pipeline stall; push/pop are ignored while it is high.
- push_addr  input  ADDR_W  return address to store (PC+1 of the CALL).
- err_clr  input  1  clears the overflow/underflow flags and leaves FAULT.
- ret_addr  output  ADDR_W  registered current top-of-stack entry; 0 when empty.
- sp  output  PTR_W  number of valid entries, 0..DEPTH.
- empty  output  1  sp==0 (combinational from sp).
- full  output  1  sp==DEPTH (combinational from sp).
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.
- fault  output  1  high while the FSM is in FAULT.

Behaviour:
- Reset (async, rst_n low):
  - All entries clear to 0; sp=0; ret_addr=0.
  - overflow=0, underflow=0; FSM=NORMAL, so fault=0.
  - Asserting reset mid-operation discards any in-flight push/pop immediately.
- Qualification:
  - do_push = push & ~stall & (state==NORMAL).
  - do_pop = pop & ~stall & (state==NORMAL).
  - Stalled requests are dropped, not queued; control re-presents them.
- Timing:
  - ret_addr is valid in the same cycle pop is asserted; the RET uses it directly.
  - Every update is visible one cycle after the qualifying edge.
- FSM states: NORMAL, FAULT.
  - NORMAL -> FAULT on overflow or underflow detection.
  - FAULT -> NORMAL on the edge where err_clr=1.
- Push only, not full:
  - mem[sp] <= push_addr; sp <= sp+1; ret_addr <= push_addr.
- Push only, full:
  - No write; sp unchanged; overflow <= 1; go to FAULT.
- Pop only, sp>1:
  - sp <= sp-1; ret_addr <= mem[sp-2]; the popped entry is not cleared.
- Pop only, sp==1:
  - sp <= 0; ret_addr <= 0.
- Pop only, empty:
  - sp unchanged; ret_addr stays 0; underflow <= 1; go to FAULT.
- Push and pop together, not empty:
  - Replace top: mem[sp-1] <= push_addr; sp unchanged; ret_addr <= push_addr.
  - No overflow even when full.
- Push and pop together, empty:
  - Treated as push only; no underflow.
- FAULT:
  - push/pop are ignored; entries, sp and ret_addr are frozen.
  - Flags hold their values.
- err_clr:
  - In FAULT: clears both flags and returns to NORMAL next cycle; stack contents are kept.
  - In NORMAL: no effect.
  - A push/pop in the same cycle as err_clr is still ignored, because state is FAULT on that edge.
- Counter: sp never wraps; it saturates logically because of the full/empty guards.
- Storage: register array, no memory macro; reads are combinational into the ret_addr register.

Test Plan (DEPTH=4, ADDR_W=19):
- Reset, then idle for 3 cycles -> sp=0, empty=1, full=0, ret_addr=0, overflow=underflow=fault=0.
- Push 0x00010, 0x00020, 0x00030 on successive cycles -> sp=3, ret_addr=0x00030. Then 3 pops -> ret_addr reads 0x00030, 0x00020, 0x00010 in the pop cycles; finally sp=0, ret_addr=0, empty=1.
- Fill with 4 pushes (full=1), then a 5th push of 0x7FFFF -> overflow=1, fault=1, sp=4, ret_addr unchanged. A following pop is ignored (sp=4). err_clr -> flags 0, fault 0. A pop then gives sp=3.
- From empty, pop -> underflow=1, fault=1, sp=0. err_clr together with push 0x00005 -> push ignored, sp=0; next cycle fault=0.
- sp=2 (top 0x00020), push 0x00099 and pop together -> sp=2, ret_addr=0x00099. Pop -> ret_addr becomes the prior entry.
- With push held high and stall=1 for 2 cycles, then stall=0 for 1 cycle -> exactly one push recorded (sp+1). Assert rst_n low mid-sequence -> all outputs reset in the same cycle without waiting for clk.
